// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encoding,
// ALU operation codes, MIPS op/func codes and datapath select constants.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_BR, S_EX_J, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_HALT
  } state_t;

  // Shared ALU encoding
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  // Opcodes (OP_REGIMM is treated as BGEZ)
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // Datapath select constants
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_A      = 2'd3;

  localparam logic [1:0] ALUB_B       = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;

  // True for the R-type functions that go through EX_R/WB_R
  function automatic logic is_r_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRA, FN_SRL, FN_ADD, FN_ADDU, FN_SUB, FN_AND,
      FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// mc_alu_decode: combinational map from op/func to ALU operation and
// immediate extension mode.
//   op, func   : instruction fields
//   alu_op     : ALU function for the execute phase
//   signed_ext : 1 = sign-extend immediate, 0 = zero-extend (logical I-types)
module mc_alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       signed_ext
);

  always_comb begin
    alu_op     = ALU_ADD;
    signed_ext = 1'b1;
    if (op == OP_RTYPE) begin
      case (func)
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRA:  alu_op = ALU_SRA;
        FN_SRL:  alu_op = ALU_SRL;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLTU: alu_op = ALU_SLTU;
        default: alu_op = ALU_ADD;
      endcase
    end else begin
      case (op)
        OP_SLTI: alu_op = ALU_SLT;
        OP_ANDI: begin alu_op = ALU_AND; signed_ext = 1'b0; end
        OP_ORI:  begin alu_op = ALU_OR;  signed_ext = 1'b0; end
        OP_XORI: begin alu_op = ALU_XOR; signed_ext = 1'b0; end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS sequencer (IF/ID/EX/MEM/WB + HALT).
// Inputs : clk, rst_n (async active-low), op, func, zero, a_sign,
//          mem_ready, resume.
// Outputs: memory port controls (mem_req, mem_write, i_or_d), IR/PC/regfile
//          enables and selects, ALU controls, lhu, halted, debug state and
//          the cycle / fetched-instruction counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             a_sign,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             signed_ext,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             lhu,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic [3:0] dec_alu_op;
  logic       dec_sext;
  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

  mc_alu_decode u_dec (
    .op         (op),
    .func       (func),
    .alu_op     (dec_alu_op),
    .signed_ext (dec_sext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_HALT)            cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_IF && mem_ready) instr_q <= instr_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    i_or_d      = 1'b0;
    pc_src      = PC_SRC_ALU;
    alu_op      = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_B;
    signed_ext  = 1'b0;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = MTR_ALUOUT;
    lhu         = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req_c = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_ID;
        end
      end
      S_ID: begin
        alu_src_b  = ALUB_IMM_SH2;
        signed_ext = 1'b1;
        case (op)
          OP_RTYPE: begin
            if (is_r_alu(func))          state_d = S_EX_R;
            else if (func == FN_JR)      state_d = S_EX_J;
            else if (func == FN_SYSCALL) state_d = S_HALT;
            else                         state_d = S_IF;
          end
          OP_J, OP_JAL:                             state_d = S_EX_J;
          OP_BEQ, OP_BNE, OP_REGIMM:                state_d = S_EX_BR;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_XORI:                 state_d = S_EX_I;
          OP_LW, OP_LHU, OP_SW:                     state_d = S_MEM_ADDR;
          default:                                  state_d = S_IF;
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
        state_d   = S_WB_R;
      end
      S_EX_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUB_IMM;
        alu_op     = dec_alu_op;
        signed_ext = dec_sext;
        state_d    = S_WB_I;
      end
      S_EX_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_SRC_ALUOUT;
        pc_write_c = (op == OP_BEQ && zero) || (op == OP_BNE && !zero) ||
                     (op == OP_REGIMM && !a_sign);
        state_d    = S_IF;
      end
      S_EX_J: begin
        pc_write_c = 1'b1;
        pc_src     = (op == OP_RTYPE) ? PC_SRC_A : PC_SRC_JUMP;
        if (op == OP_JAL) begin
          reg_write_c = 1'b1;
          reg_dst     = REG_DST_RA;
          mem_to_reg  = MTR_PC;
        end
        state_d = S_IF;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = ALUB_IMM;
        signed_ext = 1'b1;
        state_d    = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        if (mem_ready) state_d = S_IF;
      end
      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst     = REG_DST_RD;
        state_d     = S_IF;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_IF;
      end
      S_WB_MEM: begin
        reg_write_c = 1'b1;
        mem_to_reg  = MTR_MDR;
        lhu         = (op == OP_LHU);
        state_d     = S_IF;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // The state register already sits in IF during reset; gating the enables
  // with rst_n keeps the IF fetch request and strobes quiet until release.
  assign mem_req   = mem_req_c   & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;

  assign state     = state_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule
